// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, arbiter state encoding and a clog2 helper.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2
    } arb_state_e;

    // Index width for n items, never below 1 so a 2-entry index is still a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner select: first set request strictly after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o low when no request is set.
module rr_pick
    import uart_pkg::*;
#(
    parameter int P_NUM = 4,
    parameter int P_IDW = clog2(P_NUM)
) (
    input  logic [P_NUM-1:0] req_i,
    input  logic [P_IDW-1:0] ptr_i,
    output logic [P_IDW-1:0] winner_o,
    output logic             found_o
);

    // Scan from farthest to nearest so the requester closest after the pointer is the final write.
    always_comb begin
        int idx;
        winner_o = '0;
        found_o  = 1'b0;
        idx      = 0;
        for (int i = P_NUM; i >= 1; i--) begin
            idx = (int'(ptr_i) + i) % P_NUM;
            if (req_i[idx]) begin
                winner_o = P_IDW'(idx);
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX byte stream among P_NUM_REQ requesters; packet lock via UART_TX_ARB_PKT_LOCK_EN.
// Latency: request seen in IDLE -> ready pulse next cycle -> o_tx_valid the cycle after.
// Backpressure: o_tx_valid/o_tx_data held until i_tx_ready; i_cts high blocks new grants and accepts only.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int P_NUM_REQ    = 4,
    parameter  int P_DATA_WIDTH = UART_BYTE_W,
    localparam int P_ID_WIDTH   = clog2(P_NUM_REQ)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [P_NUM_REQ-1:0]              i_req_valid,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]              i_req_last,
    output logic [P_NUM_REQ-1:0]              o_req_ready,
    output logic                              o_tx_valid,
    output logic [P_DATA_WIDTH-1:0]           o_tx_data,
    input  logic                              i_tx_ready,
    input  logic                              i_cts,
    output logic [P_ID_WIDTH-1:0]             o_grant_id,
    output logic                              o_busy
);

    // Pointer starts at the last requester so requester 0 wins the first search.
    localparam logic [P_ID_WIDTH-1:0] PTR_RST = P_ID_WIDTH'(P_NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    logic [P_ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [P_ID_WIDTH-1:0]   grant_q, grant_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                    last_q, last_d;

    logic [P_ID_WIDTH-1:0]   winner;
    logic                    found;
    logic                    grant_vld;
    logic [P_DATA_WIDTH-1:0] grant_data;
    logic                    accept;

    rr_pick #(
        .P_NUM (P_NUM_REQ),
        .P_IDW (P_ID_WIDTH)
    ) u_rr_pick (
        .req_i    (i_req_valid),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    assign grant_vld  = i_req_valid[grant_q];
    assign grant_data = i_req_data[int'(grant_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
    assign accept     = (state_q == ST_GRANT) && grant_vld && !i_cts;

`ifndef UART_TX_ARB_PKT_LOCK_EN
    // Packet boundaries are meaningless when every byte re-arbitrates.
    logic unused_last;
    assign unused_last = ^i_req_last;
`endif

    // Single accept strobe, only toward the granted requester.
    always_comb begin
        o_req_ready = '0;
        if (accept) o_req_ready[grant_q] = 1'b1;
    end

    // Next-state and datapath decisions for IDLE -> GRANT -> SEND.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (found && !i_cts) begin
                    grant_d = winner;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    tx_data_d  = grant_data;
                    tx_valid_d = 1'b1;
`ifdef UART_TX_ARB_PKT_LOCK_EN
                    last_d     = i_req_last[grant_q];
`else
                    last_d     = 1'b1;
`endif
                    state_d    = ST_SEND;
                end
`ifndef UART_TX_ARB_PKT_LOCK_EN
                // Without a held packet a vanished request just frees the channel.
                else if (!grant_vld) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_SEND: begin
                if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    ptr_d      = grant_q;
                    state_d    = last_q ? ST_IDLE : ST_GRANT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; an in-flight byte is dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_RST;
            grant_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
        end
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmit byte stream between P_NUM_REQ independent requesters, such as the AXI-Lite TX FIFO and hardware status or telemetry sources. It sits between the requesters and the UART driver's user TX interface (tx_data/tx_valid/tx_ready). It honours CTS flow control and optionally holds a grant for a whole packet.

Parameters:
P_NUM_REQ, 4, number of requesters (2..16).
P_DATA_WIDTH, 8, byte width per requester.
P_ID_WIDTH, clog2(P_NUM_REQ) (min 1), width of the grant index; derived, not overridden.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
i_req_valid  in  P_NUM_REQ  per-requester byte valid
i_req_data  in  P_NUM_REQ*P_DATA_WIDTH  packed bytes; requester k occupies [k*8+7:k*8]
i_req_last  in  P_NUM_REQ  last byte of packet (used only with the optional feature)
o_req_ready  out  P_NUM_REQ  one-hot byte accept strobe
o_tx_valid  out  1  byte valid toward the UART driver
o_tx_data  out  P_DATA_WIDTH  byte toward the UART driver
i_tx_ready  in  1  UART driver ready
i_cts  in  1  clear-to-send; high = remote not ready, pause new bytes
o_grant_id  out  P_ID_WIDTH  index of the current or last granted requester
o_busy  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous, active-low (if ~reset).
- Reset values: o_tx_valid=0, o_tx_data=0, o_req_ready=0, o_grant_id=0, o_busy=0, state=IDLE, rr pointer=P_NUM_REQ-1 (requester 0 wins first).
- Every transfer is a valid & ready in the same cycle. A requester may not drop valid or change data until its ready pulse.
- FSM states: IDLE, GRANT, SEND.
- IDLE:
  - If |i_req_valid and i_cts=0: pick the winner by searching from pointer+1 upward with wrap-around.
  - Register the winner into o_grant_id and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - o_req_ready[grant] = i_req_valid[grant] & ~i_cts (combinational); all other ready bits are 0.
  - On accept: capture the data into o_tx_data, set o_tx_valid=1, latch last_q, go to SEND.
  - If the granted requester has dropped valid (lock mode only), stay in GRANT.
- SEND:
  - Hold o_tx_valid and o_tx_data stable until i_tx_ready=1.
  - On the handshake: o_tx_valid=0, pointer<=grant.
  - Go to IDLE if the packet ends (last_q, or always without the feature); otherwise go to GRANT with the same grant.
- Latency: valid at cycle 0 in IDLE -> ready at cycle 1 -> o_tx_valid at cycle 2. Maximum throughput is one byte per 2 cycles with the grant held, 3 cycles with re-arbitration.
- CTS:
  - Asserting it never retracts a byte already in SEND; that byte completes.
  - It blocks new grants and new accepts until deasserted.
- Simultaneous requests are resolved by round-robin only. No requester waits more than P_NUM_REQ-1 grants.
- Pointer wrap: after grant P_NUM_REQ-1, the search starts at 0.
- Reset mid-operation: the in-flight byte is dropped, o_tx_valid falls the cycle after reset is sampled low, and the pointer returns to its reset value.

Optional Feature:
UART_TX_ARB_PKT_LOCK_EN
- Defined: the grant is held across bytes until the byte with i_req_last=1 has been sent. The FSM returns GRANT->SEND->GRANT for the same requester; other requesters wait.
- Undefined: i_req_last is ignored and every byte is its own packet. The FSM re-arbitrates after each byte, so requesters interleave byte-by-byte.

Decomposition:
- Shared package (uart_pkg):
  - state encoding constants ST_IDLE/ST_GRANT/ST_SEND;
  - clog2 function;
  - UART byte width constant.
- Sub-module rr_pick:
  - combinational round-robin winner selection from (req vector, pointer) -> (winner index, found);
  - reusable for an RX-side dispatcher.

Test Plan:
- Single requester 2 sends 0x55, i_tx_ready=1: o_req_ready[2] pulses at cycle 1; o_tx_valid=1 and o_tx_data=0x55 at cycle 2; o_grant_id=2; back to IDLE with o_busy=0 at cycle 3.
- Requesters 0,1,3 each valid with one byte (0xA0, 0xA1, 0xA3) right after reset: output order is 0xA0, 0xA1, 0xA3. A second round with all valid continues the rotation from 0, so requester 0 is not favoured.
- Backpressure: i_tx_ready low for 5 cycles while o_tx_valid=1: o_tx_data stays constant, no o_req_ready pulses, byte transfers on the cycle ready rises.
- CTS: i_cts=1 with requests pending -> no grant and o_req_ready=0. Asserted during SEND -> that byte still completes and the next accept is delayed until i_cts=0.
- Requester 0 has a 3-byte packet (0x10, 0x11, 0x12 with last on 0x12) and requester 1 has 0x20:
  - with UART_TX_ARB_PKT_LOCK_EN: output 0x10, 0x11, 0x12, 0x20;
  - without it: 0x10, 0x20, 0x11, 0x12.
- reset=0 for one cycle while in SEND: o_tx_valid=0 the cycle after reset is sampled low. With requester 0 and requester 3 both valid afterwards, requester 0 is granted first.
